dispatch_rename_multi: RTL and testbench

N-wide in-order dispatch and rename stage for the R10K core. It sits between the instruction buffer and the ROB, RS banks, free list and branch stack. Each cycle it computes how many leading instructions can dispatch and renames their sources and destinations through an internal map table. It tracks a speculative branch mask, emits branch checkpoints, and restores state on a mispredict. It generalises the single-RS dispatch to multiple typed RS channels, configurable width and a configurable number of branch-mask bits.

---
 rtl/dispatch_rename_multi_pkg.sv | 30 +++
 rtl/dispatch_rename_multi_if.sv | 61 ++++++
 rtl/dispatch_rename_multi_dispatch_count.sv | 65 ++++++
 rtl/dispatch_rename_multi.sv | 154 +++++++++++++++
 tb/tb_dispatch_rename_multi.sv | 337 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dispatch_rename_multi_pkg.sv
// Shared types for the N-wide dispatch/rename stage: default sizing, register and
// branch-mask index types, RS channel encoding and the per-slot rename result.
package dispatch_rename_multi_pkg;

  localparam int N_DEF         = 3;
  localparam int ARCH_REGS_DEF = 32;
  localparam int PHYS_REGS_DEF = 64;
  localparam int NUM_RS_CH_DEF = 3;
  localparam int B_MASK_W_DEF  = 4;
  localparam int PREG_BITS_DEF = $clog2(PHYS_REGS_DEF);
  localparam int AREG_BITS     = 5;

  typedef logic [PREG_BITS_DEF-1:0] PHYS_REG_IDX;
  typedef logic [B_MASK_W_DEF-1:0]  B_MASK;

  typedef enum logic [1:0] {
    RS_ALU  = 2'd0,
    RS_MULT = 2'd1,
    RS_MEM  = 2'd2
  } rs_ch_e;

  typedef struct packed {
    PHYS_REG_IDX dest;
    PHYS_REG_IDX src1;
    PHYS_REG_IDX src2;
    PHYS_REG_IDX told;
    B_MASK       b_mask;
  } RENAME_PACKET;

endpackage

// File: rtl/dispatch_rename_multi_if.sv
// Bundle of every dispatch/rename signal except clock and reset. The master side is
// the instruction buffer / backend environment, the slave side is the rename stage.
interface dispatch_rename_multi_if
  import dispatch_rename_multi_pkg::*;
#(
  parameter int N         = N_DEF,
  parameter int ARCH_REGS = ARCH_REGS_DEF,
  parameter int PHYS_REGS = PHYS_REGS_DEF,
  parameter int NUM_RS_CH = NUM_RS_CH_DEF,
  parameter int B_MASK_W  = B_MASK_W_DEF
);
  localparam int PREG_BITS = $clog2(PHYS_REGS);
  localparam int CNT_W     = $clog2(N + 1);
  localparam int CH_W      = (NUM_RS_CH > 1) ? $clog2(NUM_RS_CH) : 1;

  logic [N-1:0]                          inst_valid;
  logic [N-1:0][AREG_BITS-1:0]           inst_dest;
  logic [N-1:0][AREG_BITS-1:0]           inst_src1;
  logic [N-1:0][AREG_BITS-1:0]           inst_src2;
  logic [N-1:0][CH_W-1:0]                inst_rs_ch;
  logic [N-1:0]                          inst_is_branch;
  logic                                  stall;
  logic [CNT_W-1:0]                      rob_spots;
  logic [NUM_RS_CH-1:0][CNT_W-1:0]       rs_spots;
  logic [CNT_W-1:0]                      free_regs_avail;
  logic [N-1:0][PREG_BITS-1:0]           free_regs;
  logic                                  resolve_valid;
  logic [B_MASK_W-1:0]                   resolve_mask;
  logic                                  mispredict;
  logic [ARCH_REGS-1:0][PREG_BITS-1:0]   restore_map;
  logic [B_MASK_W-1:0]                   restore_b_mask;

  logic [CNT_W-1:0]                      num_dispatched;
  logic [CNT_W-1:0]                      num_allocated;
  logic [N-1:0][PREG_BITS-1:0]           out_dest_preg;
  logic [N-1:0][PREG_BITS-1:0]           out_src1_preg;
  logic [N-1:0][PREG_BITS-1:0]           out_src2_preg;
  logic [N-1:0][PREG_BITS-1:0]           out_told;
  logic [N-1:0][B_MASK_W-1:0]            out_b_mask;
  logic [N-1:0]                          ckpt_valid;
  logic [N-1:0][B_MASK_W-1:0]            ckpt_bit;
  logic [N-1:0][ARCH_REGS-1:0][PREG_BITS-1:0] ckpt_map;
  logic [N-1:0][B_MASK_W-1:0]            ckpt_b_mask;

  modport master (
    output inst_valid, inst_dest, inst_src1, inst_src2, inst_rs_ch, inst_is_branch,
           stall, rob_spots, rs_spots, free_regs_avail, free_regs,
           resolve_valid, resolve_mask, mispredict, restore_map, restore_b_mask,
    input  num_dispatched, num_allocated, out_dest_preg, out_src1_preg, out_src2_preg,
           out_told, out_b_mask, ckpt_valid, ckpt_bit, ckpt_map, ckpt_b_mask
  );

  modport slave (
    input  inst_valid, inst_dest, inst_src1, inst_src2, inst_rs_ch, inst_is_branch,
           stall, rob_spots, rs_spots, free_regs_avail, free_regs,
           resolve_valid, resolve_mask, mispredict, restore_map, restore_b_mask,
    output num_dispatched, num_allocated, out_dest_preg, out_src1_preg, out_src2_preg,
           out_told, out_b_mask, ckpt_valid, ckpt_bit, ckpt_map, ckpt_b_mask
  );

endinterface

// File: rtl/dispatch_rename_multi_dispatch_count.sv
// In-order dispatch limiter: accepts the longest prefix of slots whose cumulative ROB,
// RS-channel, free-preg and branch-mask demands all fit, and numbers the allocating slots.
module dispatch_rename_multi_dispatch_count
  import dispatch_rename_multi_pkg::*;
#(
  parameter int N         = N_DEF,
  parameter int NUM_RS_CH = NUM_RS_CH_DEF,
  parameter int B_MASK_W  = B_MASK_W_DEF,
  parameter int CNT_W     = $clog2(N + 1),
  parameter int CH_W      = (NUM_RS_CH > 1) ? $clog2(NUM_RS_CH) : 1,
  parameter int IDX_W     = (N > 1) ? $clog2(N) : 1,
  parameter int FB_W      = $clog2(B_MASK_W + 1)
) (
  input  logic                            block,
  input  logic [N-1:0]                    inst_valid,
  input  logic [N-1:0]                    inst_alloc,
  input  logic [N-1:0][CH_W-1:0]          inst_rs_ch,
  input  logic [N-1:0]                    inst_is_branch,
  input  logic [CNT_W-1:0]                rob_spots,
  input  logic [NUM_RS_CH-1:0][CNT_W-1:0] rs_spots,
  input  logic [CNT_W-1:0]                free_regs_avail,
  input  logic [FB_W-1:0]                 free_b_bits,
  output logic [CNT_W-1:0]                num_dispatched,
  output logic [CNT_W-1:0]                num_allocated,
  output logic [N-1:0][IDX_W-1:0]         alloc_idx
);
  // Wide internal counters keep every comparison free of carry-out corner cases.
  localparam int CW = 8;

  logic [CW-1:0]                 n_cnt;
  logic [CW-1:0]                 a_cnt;
  logic [CW-1:0]                 b_cnt;
  logic [NUM_RS_CH-1:0][CW-1:0]  ch_cnt;
  logic                          ok;
  logic                          fits;

  always_comb begin
    n_cnt     = '0;
    a_cnt     = '0;
    b_cnt     = '0;
    ch_cnt    = '0;
    ok        = !block;
    fits      = 1'b0;
    alloc_idx = '0;
    for (int i = 0; i < N; i++) begin
      alloc_idx[i] = IDX_W'(a_cnt);
      fits = inst_valid[i]
          && (32'(inst_rs_ch[i]) < NUM_RS_CH)
          && ((n_cnt + CW'(1)) <= CW'(rob_spots))
          && ((ch_cnt[inst_rs_ch[i]] + CW'(1)) <= CW'(rs_spots[inst_rs_ch[i]]))
          && ((a_cnt + CW'(inst_alloc[i])) <= CW'(free_regs_avail))
          && ((b_cnt + CW'(inst_is_branch[i])) <= CW'(free_b_bits));
      ok = ok && fits;
      if (ok) begin
        n_cnt                  = n_cnt + CW'(1);
        a_cnt                  = a_cnt + CW'(inst_alloc[i]);
        b_cnt                  = b_cnt + CW'(inst_is_branch[i]);
        ch_cnt[inst_rs_ch[i]]  = ch_cnt[inst_rs_ch[i]] + CW'(1);
      end
    end
    num_dispatched = CNT_W'(n_cnt);
    num_allocated  = CNT_W'(a_cnt);
  end

endmodule

// File: rtl/dispatch_rename_multi.sv
// N-wide rename/dispatch: map table with intra-group forwarding, speculative branch
// mask allocation with per-branch checkpoints, and restore on mispredict.
module dispatch_rename_multi
  import dispatch_rename_multi_pkg::*;
#(
  parameter int N         = N_DEF,
  parameter int ARCH_REGS = ARCH_REGS_DEF,
  parameter int PHYS_REGS = PHYS_REGS_DEF,
  parameter int NUM_RS_CH = NUM_RS_CH_DEF,
  parameter int B_MASK_W  = B_MASK_W_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  dispatch_rename_multi_if.slave bus
);
  localparam int PREG_BITS = $clog2(PHYS_REGS);
  localparam int CNT_W     = $clog2(N + 1);
  localparam int CH_W      = (NUM_RS_CH > 1) ? $clog2(NUM_RS_CH) : 1;
  localparam int IDX_W     = (N > 1) ? $clog2(N) : 1;
  localparam int FB_W      = $clog2(B_MASK_W + 1);

  typedef logic [ARCH_REGS-1:0][PREG_BITS-1:0] map_t;

  map_t                    map_q, map_d;
  logic [B_MASK_W-1:0]     b_mask_q, b_mask_d;

  map_t                    map_w;
  logic [B_MASK_W-1:0]     mask_w;
  logic [B_MASK_W-1:0]     bit_w;
  logic                    live;

  logic                    flush;
  logic                    correct_res;
  logic [B_MASK_W-1:0]     eff_mask;
  logic [FB_W-1:0]         free_b_bits;
  logic [N-1:0]            inst_alloc;
  logic [CNT_W-1:0]        k;
  logic [CNT_W-1:0]        n_alloc;
  logic [N-1:0][IDX_W-1:0] alloc_idx;

  function automatic logic [B_MASK_W-1:0] lowest_zero(input logic [B_MASK_W-1:0] m);
    lowest_zero = '0;
    for (int b = B_MASK_W - 1; b >= 0; b--) begin
      if (!m[b]) lowest_zero = B_MASK_W'(1) << b;
    end
  endfunction

  function automatic logic [FB_W-1:0] count_zeros(input logic [B_MASK_W-1:0] m);
    count_zeros = '0;
    for (int b = 0; b < B_MASK_W; b++) begin
      count_zeros = count_zeros + FB_W'(!m[b]);
    end
  endfunction

  assign flush       = bus.resolve_valid && bus.mispredict;
  assign correct_res = bus.resolve_valid && !bus.mispredict;
  // A branch resolving correctly frees its bit for reuse in this very cycle.
  assign eff_mask    = correct_res ? (b_mask_q & ~bus.resolve_mask) : b_mask_q;
  assign free_b_bits = count_zeros(eff_mask);

  always_comb begin
    inst_alloc = '0;
    for (int i = 0; i < N; i++) inst_alloc[i] = |bus.inst_dest[i];
  end

  dispatch_rename_multi_dispatch_count #(
    .N         (N),
    .NUM_RS_CH (NUM_RS_CH),
    .B_MASK_W  (B_MASK_W)
  ) u_count (
    .block           (reset || bus.stall || flush),
    .inst_valid      (bus.inst_valid),
    .inst_alloc      (inst_alloc),
    .inst_rs_ch      (bus.inst_rs_ch),
    .inst_is_branch  (bus.inst_is_branch),
    .rob_spots       (bus.rob_spots),
    .rs_spots        (bus.rs_spots),
    .free_regs_avail (bus.free_regs_avail),
    .free_b_bits     (free_b_bits),
    .num_dispatched  (k),
    .num_allocated   (n_alloc),
    .alloc_idx       (alloc_idx)
  );

  assign bus.num_dispatched = k;
  assign bus.num_allocated  = n_alloc;

  always_comb begin
    map_w             = map_q;
    mask_w            = eff_mask;
    bit_w             = '0;
    live              = 1'b0;
    map_d             = map_q;
    b_mask_d          = eff_mask;
    bus.out_dest_preg = '0;
    bus.out_src1_preg = '0;
    bus.out_src2_preg = '0;
    bus.out_told      = '0;
    bus.out_b_mask    = '0;
    bus.ckpt_valid    = '0;
    bus.ckpt_bit      = '0;
    bus.ckpt_map      = '0;
    bus.ckpt_b_mask   = '0;
    // map_w/mask_w walk the group slot by slot, so each slot sees older slots' effects.
    for (int i = 0; i < N; i++) begin
      live = (i < int'(k));
      bus.out_src1_preg[i] = (bus.inst_src1[i] == '0) ? '0 : map_w[bus.inst_src1[i]];
      bus.out_src2_preg[i] = (bus.inst_src2[i] == '0) ? '0 : map_w[bus.inst_src2[i]];
      bus.out_b_mask[i]    = mask_w;
      if (inst_alloc[i]) begin
        bus.out_told[i]          = map_w[bus.inst_dest[i]];
        bus.out_dest_preg[i]     = bus.free_regs[alloc_idx[i]];
        map_w[bus.inst_dest[i]]  = bus.free_regs[alloc_idx[i]];
      end
      if (bus.inst_is_branch[i]) begin
        bit_w               = lowest_zero(mask_w);
        mask_w              = mask_w | bit_w;
        bus.ckpt_valid[i]   = live;
        bus.ckpt_bit[i]     = bit_w;
        bus.ckpt_map[i]     = map_w;
        bus.ckpt_b_mask[i]  = mask_w;
      end
      if (live) begin
        map_d    = map_w;
        b_mask_d = mask_w;
      end
    end
    if (flush) begin
      map_d    = bus.restore_map;
      b_mask_d = bus.restore_b_mask & ~bus.resolve_mask;
    end
    if (reset) begin
      bus.out_dest_preg = '0;
      bus.out_src1_preg = '0;
      bus.out_src2_preg = '0;
      bus.out_told      = '0;
      bus.out_b_mask    = '0;
      bus.ckpt_bit      = '0;
      bus.ckpt_map      = '0;
      bus.ckpt_b_mask   = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int a = 0; a < ARCH_REGS; a++) map_q[a] <= PREG_BITS'(a);
      b_mask_q <= '0;
    end else begin
      map_q    <= map_d;
      b_mask_q <= b_mask_d;
    end
  end

endmodule

// File: tb/tb_dispatch_rename_multi.sv
// Directed bench for dispatch_rename_multi: a table of single-cycle rename vectors
// followed by hand-written branch, mispredict, resolve and reset sequences.
module tb_dispatch_rename_multi;
  import dispatch_rename_multi_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dispatch_rename_multi_if bus ();

  dispatch_rename_multi dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    int valid;
    int br;
    int dest[3];
    int s1[3];
    int s2[3];
    int ch[3];
    int stall;
    int rob;
    int avail;
    int rs[3];
    int fr[3];
    int exp_nd;
    int exp_na;
    int e_s1[3];
    int e_s2[3];
    int e_d[3];
    int e_t[3];
  } vec_t;

  localparam int NV = 10;
  vec_t vecs[NV];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  function automatic vec_t dflt();
    vec_t v;
    v.valid = 0; v.br = 0; v.stall = 0; v.rob = 3; v.avail = 3;
    v.exp_nd = 0; v.exp_na = 0;
    for (int i = 0; i < 3; i++) begin
      v.dest[i] = 0; v.s1[i] = 0; v.s2[i] = 0; v.ch[i] = 0;
      v.rs[i] = 3; v.fr[i] = 40 + i;
      v.e_s1[i] = 0; v.e_s2[i] = 0; v.e_d[i] = 0; v.e_t[i] = 0;
    end
    return v;
  endfunction

  task automatic clear_inputs();
    bus.inst_valid      = '0;
    bus.inst_dest       = '0;
    bus.inst_src1       = '0;
    bus.inst_src2       = '0;
    bus.inst_rs_ch      = '0;
    bus.inst_is_branch  = '0;
    bus.stall           = 1'b0;
    bus.rob_spots       = 2'd3;
    bus.free_regs_avail = 2'd3;
    for (int i = 0; i < 3; i++) begin
      bus.rs_spots[i]  = 2'd3;
      bus.free_regs[i] = 6'(40 + i);
    end
    bus.resolve_valid   = 1'b0;
    bus.resolve_mask    = '0;
    bus.mispredict      = 1'b0;
    bus.restore_map     = '0;
    bus.restore_b_mask  = '0;
  endtask

  task automatic set_slot(input int i, input int d, input int a, input int b,
                          input int ch, input bit br);
    bus.inst_valid[i]     = 1'b1;
    bus.inst_dest[i]      = 5'(d);
    bus.inst_src1[i]      = 5'(a);
    bus.inst_src2[i]      = 5'(b);
    bus.inst_rs_ch[i]     = 2'(ch);
    bus.inst_is_branch[i] = br;
  endtask

  task automatic drive_vec(input vec_t v);
    clear_inputs();
    for (int i = 0; i < 3; i++) begin
      bus.inst_valid[i]     = v.valid[i];
      bus.inst_is_branch[i] = v.br[i];
      bus.inst_dest[i]      = 5'(v.dest[i]);
      bus.inst_src1[i]      = 5'(v.s1[i]);
      bus.inst_src2[i]      = 5'(v.s2[i]);
      bus.inst_rs_ch[i]     = 2'(v.ch[i]);
      bus.rs_spots[i]       = 2'(v.rs[i]);
      bus.free_regs[i]      = 6'(v.fr[i]);
    end
    bus.stall           = (v.stall != 0);
    bus.rob_spots       = 2'(v.rob);
    bus.free_regs_avail = 2'(v.avail);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "timeout");
  end

  initial begin
    // x3 = x1 + x2
    vecs[0] = dflt(); vecs[0].valid = 1;
    vecs[0].dest[0] = 3; vecs[0].s1[0] = 1; vecs[0].s2[0] = 2;
    vecs[0].exp_nd = 1; vecs[0].exp_na = 1;
    vecs[0].e_s1[0] = 1; vecs[0].e_s2[0] = 2; vecs[0].e_d[0] = 40; vecs[0].e_t[0] = 3;
    // x4 = x3 + x0 : reads the committed rename of x3
    vecs[1] = dflt(); vecs[1].valid = 1;
    vecs[1].dest[0] = 4; vecs[1].s1[0] = 3; vecs[1].s2[0] = 0;
    vecs[1].fr = '{43, 44, 45};
    vecs[1].exp_nd = 1; vecs[1].exp_na = 1;
    vecs[1].e_s1[0] = 40; vecs[1].e_s2[0] = 0; vecs[1].e_d[0] = 43; vecs[1].e_t[0] = 4;
    // {x5=x1+x1; x6=x5+x5; x5=x6+x0} : intra-group forwarding
    vecs[2] = dflt(); vecs[2].valid = 7;
    vecs[2].dest = '{5, 6, 5}; vecs[2].s1 = '{1, 5, 6}; vecs[2].s2 = '{1, 5, 0};
    vecs[2].exp_nd = 3; vecs[2].exp_na = 3;
    vecs[2].e_s1 = '{1, 40, 41}; vecs[2].e_s2 = '{1, 40, 0};
    vecs[2].e_d  = '{40, 41, 42}; vecs[2].e_t  = '{5, 6, 40};
    // three MULT ops with one MULT RS entry
    vecs[3] = dflt(); vecs[3].valid = 7; vecs[3].ch = '{1, 1, 1}; vecs[3].rs = '{3, 1, 3};
    vecs[3].dest = '{7, 8, 9}; vecs[3].s1 = '{5, 3, 1}; vecs[3].s2 = '{6, 4, 1};
    vecs[3].fr = '{50, 51, 52};
    vecs[3].exp_nd = 1; vecs[3].exp_na = 1;
    vecs[3].e_s1[0] = 42; vecs[3].e_s2[0] = 41; vecs[3].e_d[0] = 50; vecs[3].e_t[0] = 7;
    // stalled group must not commit
    vecs[4] = dflt(); vecs[4].valid = 7; vecs[4].stall = 1;
    vecs[4].dest = '{7, 8, 9}; vecs[4].s1 = '{5, 3, 1}; vecs[4].s2 = '{6, 4, 1};
    vecs[4].fr = '{60, 61, 62};
    // x10 = x7 + x5 : x7 still maps to 50
    vecs[5] = dflt(); vecs[5].valid = 1;
    vecs[5].dest[0] = 10; vecs[5].s1[0] = 7; vecs[5].s2[0] = 5;
    vecs[5].fr = '{53, 54, 55};
    vecs[5].exp_nd = 1; vecs[5].exp_na = 1;
    vecs[5].e_s1[0] = 50; vecs[5].e_s2[0] = 42; vecs[5].e_d[0] = 53; vecs[5].e_t[0] = 10;
    // ROB limit of 2
    vecs[6] = dflt(); vecs[6].valid = 7; vecs[6].rob = 2;
    vecs[6].dest = '{11, 12, 13}; vecs[6].s1 = '{0, 11, 12}; vecs[6].s2 = '{0, 0, 12};
    vecs[6].fr = '{54, 55, 56};
    vecs[6].exp_nd = 2; vecs[6].exp_na = 2;
    vecs[6].e_s1 = '{0, 54, 0}; vecs[6].e_s2 = '{0, 0, 0};
    vecs[6].e_d  = '{54, 55, 0}; vecs[6].e_t  = '{11, 12, 0};
    // one free preg: store (dest 0) passes, second allocator blocks
    vecs[7] = dflt(); vecs[7].valid = 7; vecs[7].avail = 1; vecs[7].ch = '{0, 2, 0};
    vecs[7].dest = '{14, 0, 15}; vecs[7].s1 = '{11, 14, 1}; vecs[7].s2 = '{12, 10, 1};
    vecs[7].fr = '{57, 58, 59};
    vecs[7].exp_nd = 2; vecs[7].exp_na = 1;
    vecs[7].e_s1 = '{54, 57, 0}; vecs[7].e_s2 = '{55, 53, 0};
    vecs[7].e_d  = '{57, 0, 0};  vecs[7].e_t  = '{14, 0, 0};
    // valid gap stops the scan at slot 1
    vecs[8] = dflt(); vecs[8].valid = 5;
    vecs[8].dest = '{1, 0, 2}; vecs[8].s1 = '{14, 0, 1}; vecs[8].s2 = '{14, 0, 1};
    vecs[8].fr = '{2, 3, 4};
    vecs[8].exp_nd = 1; vecs[8].exp_na = 1;
    vecs[8].e_s1[0] = 57; vecs[8].e_s2[0] = 57; vecs[8].e_d[0] = 2; vecs[8].e_t[0] = 1;
    // empty group
    vecs[9] = dflt();

    clear_inputs();
    rst = 1'b1;
    next_cycle();
    next_cycle();
    set_slot(0, 3, 1, 2, int'(RS_ALU), 1'b0);
    @(negedge clk);
    chk("rst.nd", int'(bus.num_dispatched), 0);
    chk("rst.na", int'(bus.num_allocated), 0);
    chk("rst.dest0", int'(bus.out_dest_preg[0]), 0);
    next_cycle();
    rst = 1'b0;

    for (int v = 0; v < NV; v++) begin
      drive_vec(vecs[v]);
      @(negedge clk);
      chk($sformatf("v%0d.nd", v), int'(bus.num_dispatched), vecs[v].exp_nd);
      chk($sformatf("v%0d.na", v), int'(bus.num_allocated), vecs[v].exp_na);
      for (int s = 0; s < 3; s++) begin
        if (s < vecs[v].exp_nd) begin
          chk($sformatf("v%0d.s%0d.src1", v, s), int'(bus.out_src1_preg[s]), vecs[v].e_s1[s]);
          chk($sformatf("v%0d.s%0d.src2", v, s), int'(bus.out_src2_preg[s]), vecs[v].e_s2[s]);
          chk($sformatf("v%0d.s%0d.dest", v, s), int'(bus.out_dest_preg[s]), vecs[v].e_d[s]);
          chk($sformatf("v%0d.s%0d.told", v, s), int'(bus.out_told[s]), vecs[v].e_t[s]);
        end
      end
      next_cycle();
    end

    // Reset in the middle of traffic: outputs zero, map back to identity.
    clear_inputs();
    set_slot(0, 20, 14, 5, int'(RS_ALU), 1'b0);
    set_slot(1, 21, 3, 7, int'(RS_ALU), 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst.nd", int'(bus.num_dispatched), 0);
    chk("mrst.src1", int'(bus.out_src1_preg[0]), 0);
    chk("mrst.ckv", int'(bus.ckpt_valid), 0);
    next_cycle();
    rst = 1'b0;
    clear_inputs();
    set_slot(0, 0, 14, 5, int'(RS_ALU), 1'b0);
    @(negedge clk);
    chk("mrst.map14", int'(bus.out_src1_preg[0]), 14);
    chk("mrst.map5", int'(bus.out_src2_preg[0]), 5);
    next_cycle();

    // Three branches from an empty mask; slot 0 also writes x3.
    clear_inputs();
    set_slot(0, 3, 1, 0, int'(RS_ALU), 1'b1);
    set_slot(1, 0, 3, 0, int'(RS_ALU), 1'b1);
    set_slot(2, 0, 0, 0, int'(RS_ALU), 1'b1);
    @(negedge clk);
    chk("b1.nd", int'(bus.num_dispatched), 3);
    chk("b1.na", int'(bus.num_allocated), 1);
    chk("b1.ckv", int'(bus.ckpt_valid), 7);
    chk("b1.bit0", int'(bus.ckpt_bit[0]), 1);
    chk("b1.bit1", int'(bus.ckpt_bit[1]), 2);
    chk("b1.bit2", int'(bus.ckpt_bit[2]), 4);
    chk("b1.bm1", int'(bus.out_b_mask[1]), 1);
    chk("b1.bm2", int'(bus.out_b_mask[2]), 3);
    chk("b1.ckbm2", int'(bus.ckpt_b_mask[2]), 7);
    chk("b1.ckmap0", int'(bus.ckpt_map[0][3]), 40);
    chk("b1.src1_fwd", int'(bus.out_src1_preg[1]), 40);
    next_cycle();

    // Correct resolve of bit 1 with nothing dispatching: mask 0111 -> 0101.
    clear_inputs();
    bus.resolve_valid = 1'b1;
    bus.resolve_mask  = 4'b0010;
    @(negedge clk);
    chk("b2.nd", int'(bus.num_dispatched), 0);
    next_cycle();

    // Three branches with mask 0101: only two bits left.
    clear_inputs();
    set_slot(0, 0, 0, 0, int'(RS_ALU), 1'b1);
    set_slot(1, 0, 0, 0, int'(RS_ALU), 1'b1);
    set_slot(2, 0, 0, 0, int'(RS_ALU), 1'b1);
    @(negedge clk);
    chk("b3.nd", int'(bus.num_dispatched), 2);
    chk("b3.ckv", int'(bus.ckpt_valid), 3);
    chk("b3.bit0", int'(bus.ckpt_bit[0]), 2);
    chk("b3.bit1", int'(bus.ckpt_bit[1]), 8);
    chk("b3.bm0", int'(bus.out_b_mask[0]), 5);
    chk("b3.bm1", int'(bus.out_b_mask[1]), 7);
    next_cycle();

    // Mask now full: a branch cannot dispatch.
    clear_inputs();
    set_slot(0, 0, 0, 0, int'(RS_ALU), 1'b1);
    @(negedge clk);
    chk("b4.nd", int'(bus.num_dispatched), 0);
    chk("b4.ckv", int'(bus.ckpt_valid), 0);
    next_cycle();

    // Mispredict with valid instructions present.
    clear_inputs();
    set_slot(0, 0, 0, 0, int'(RS_ALU), 1'b1);
    set_slot(1, 4, 1, 2, int'(RS_ALU), 1'b0);
    bus.resolve_valid  = 1'b1;
    bus.mispredict     = 1'b1;
    bus.resolve_mask   = 4'b0010;
    bus.restore_b_mask = 4'b0011;
    for (int a = 0; a < 32; a++) bus.restore_map[a] = (a == 0) ? 6'd0 : 6'(a + 20);
    @(negedge clk);
    chk("m1.nd", int'(bus.num_dispatched), 0);
    chk("m1.na", int'(bus.num_allocated), 0);
    chk("m1.ckv", int'(bus.ckpt_valid), 0);
    next_cycle();

    // After restore: map is the checkpoint, mask is 0001.
    clear_inputs();
    set_slot(0, 0, 5, 9, int'(RS_ALU), 1'b1);
    set_slot(1, 0, 31, 0, int'(RS_ALU), 1'b1);
    set_slot(2, 0, 1, 3, int'(RS_ALU), 1'b1);
    @(negedge clk);
    chk("m2.nd", int'(bus.num_dispatched), 3);
    chk("m2.bm0", int'(bus.out_b_mask[0]), 1);
    chk("m2.bit0", int'(bus.ckpt_bit[0]), 2);
    chk("m2.bit2", int'(bus.ckpt_bit[2]), 8);
    chk("m2.x5", int'(bus.out_src1_preg[0]), 25);
    chk("m2.x9", int'(bus.out_src2_preg[0]), 29);
    chk("m2.x31", int'(bus.out_src1_preg[1]), 51);
    chk("m2.x3", int'(bus.out_src2_preg[2]), 23);
    next_cycle();

    // Same-cycle correct resolve and branch dispatch reuse bit 0.
    clear_inputs();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    set_slot(0, 0, 0, 0, int'(RS_ALU), 1'b1);
    @(negedge clk);
    chk("c1.bit0", int'(bus.ckpt_bit[0]), 1);
    next_cycle();
    clear_inputs();
    set_slot(0, 0, 0, 0, int'(RS_ALU), 1'b1);
    bus.resolve_valid = 1'b1;
    bus.resolve_mask  = 4'b0001;
    @(negedge clk);
    chk("c2.nd", int'(bus.num_dispatched), 1);
    chk("c2.bit0", int'(bus.ckpt_bit[0]), 1);
    chk("c2.bm0", int'(bus.out_b_mask[0]), 0);
    chk("c2.ckbm0", int'(bus.ckpt_b_mask[0]), 1);
    next_cycle();
    clear_inputs();
    set_slot(0, 5, 3, 0, int'(RS_MEM), 1'b0);
    @(negedge clk);
    chk("c3.bm0", int'(bus.out_b_mask[0]), 1);
    chk("c3.src1", int'(bus.out_src1_preg[0]), 3);
    chk("c3.dest", int'(bus.out_dest_preg[0]), 40);
    next_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
